serial_add_driver: RTL and testbench

- Master end of the bit-serial adder interface.
- Accepts two parallel WIDTH-bit operands and streams them LSB-first into the bit-serial full adder cell, which has inputs a, b, C_EN, rst and output s.
- Steps the cell's carry latch, collects the serial sum bits and reassembles them into a parallel result.
- Sits between the parallel datapath and the serial adder cell, replacing the manual sequencing currently done by hand in benches.

---
 rtl/serial_add_driver.sv | 127 ++++++++++++
 tb/tb_serial_add_driver.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_add_driver.sv
// rtl/serial_add_driver.sv - master sequencer streaming two operands LSB-first into a bit-serial full-adder cell
module serial_add_driver #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] num1,
    input  logic [WIDTH-1:0] num2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             a,
    output logic             b,
    output logic             C_EN,
    output logic             adder_rst,
    input  logic             s
);

    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLR,
        EVAL,
        LATCH,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] op1_q, op1_d;
    logic [WIDTH-1:0] op2_q, op2_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             c_en_q, c_en_d;
    logic             adder_rst_q, adder_rst_d;

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign a         = a_q;
    assign b         = b_q;
    assign C_EN      = c_en_q;
    assign adder_rst = adder_rst_q;

    // Next-state logic; outputs are decoded from the next state so they are registered yet aligned with the state
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        op1_d    = op1_q;
        op2_d    = op2_q;
        shadow_d = shadow_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op1_d   = num1;
                    op2_d   = num2;
                    idx_d   = '0;
                    state_d = CLR;
                end
            end
            CLR: state_d = EVAL;
            EVAL: begin
                shadow_d[idx_q] = s;
                state_d         = LATCH;
            end
            LATCH: begin
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = EVAL;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d      = (state_d != IDLE);
        done_d      = (state_d == DONE);
        c_en_d      = (state_d == LATCH);
        adder_rst_d = (state_d == CLR);
        // a/b only move on entry to EVAL, so they stay put through LATCH while the carry is latched
        a_d         = (state_d == EVAL) ? op1_q[idx_d] : a_q;
        b_d         = (state_d == EVAL) ? op2_q[idx_d] : b_q;
        result_d    = (state_d == DONE) ? shadow_q : result_q;
    end

    // State, datapath and output registers; async reset aborts any operation and drops the old result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            shadow_q    <= '0;
            result_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            a_q         <= 1'b0;
            b_q         <= 1'b0;
            c_en_q      <= 1'b0;
            adder_rst_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            op1_q       <= op1_d;
            op2_q       <= op2_d;
            shadow_q    <= shadow_d;
            result_q    <= result_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_en_q      <= c_en_d;
            adder_rst_q <= adder_rst_d;
        end
    end

endmodule

// File: tb/tb_serial_add_driver.sv
// tb/tb_serial_add_driver.sv - self-checking bench for serial_add_driver with a behavioural adder cell
module tb_serial_add_driver;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] num1 = '0;
    logic [W-1:0] num2 = '0;
    logic         busy, done, a, b, C_EN, adder_rst, s;
    logic [W-1:0] result;

    serial_add_driver #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num1      (num1),
        .num2      (num2),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .a         (a),
        .b         (b),
        .C_EN      (C_EN),
        .adder_rst (adder_rst),
        .s         (s)
    );

    always #5 clk = ~clk;

    // Bit-serial full adder cell: combinational sum, carry latched when C_EN, cleared by its own reset
    logic carry = 1'b0;
    assign s = a ^ b ^ carry;
    always @(posedge clk) begin
        if (adder_rst)  carry <= 1'b0;
        else if (C_EN)  carry <= (a & b) | (a & carry) | (b & carry);
    end

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int t0 = 0;
    int cen_cnt = 0;
    int arst_cnt = 0;
    int arst_cyc = -1;
    int done_cnt = 0;
    int s_idx = 0;
    logic [W-1:0] sseq = '0;
    logic a_ev = 1'b0;
    logic b_ev = 1'b0;
    logic [W-1:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: scoreboard compare on done, cell-interface invariants, serial sum capture
    always @(negedge clk) begin
        if (!rst) begin
            chk("cen_and_rst_exclusive", {31'b0, C_EN & adder_rst}, 32'd0);
            if (C_EN) begin
                cen_cnt++;
                chk("a_stable_in_latch", {31'b0, a}, {31'b0, a_ev});
                chk("b_stable_in_latch", {31'b0, b}, {31'b0, b_ev});
            end
            if (adder_rst) begin
                arst_cnt++;
                arst_cyc = cyc;
            end
            if (busy && !C_EN && !adder_rst && !done) begin
                a_ev = a;
                b_ev = b;
                if (s_idx < W) sseq[s_idx] = s;
                s_idx++;
            end
            if (done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    chk("result", {24'b0, result}, {24'b0, sb.pop_front()});
                end
            end
        end
    end

    task automatic start_op(input logic [W-1:0] n1, input logic [W-1:0] n2);
        num1 = n1;
        num2 = n2;
        start = 1'b1;
        t0 = cyc;
        cen_cnt = 0;
        arst_cnt = 0;
        arst_cyc = -1;
        done_cnt = 0;
        s_idx = 0;
        sb.push_back(n1 + n2);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (!done && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (!done) chk({tag, "_timeout"}, 32'd0, 32'd1);
        else       chk({tag, "_latency"}, cyc - t0, 32'd18);
    endtask

    initial begin
        // Reset values
        repeat (5) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_result", {24'b0, result}, 32'd0);
        chk("rst_ab", {30'b0, a, b}, 32'd0);
        chk("rst_cen_arst", {30'b0, C_EN, adder_rst}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Wrap-around and serial sum sequence
        start_op(8'hAA, 8'hAA);
        wait_done("wrap");
        chk("wrap_sseq", {24'b0, sseq}, 32'h54);
        @(negedge clk);

        // Full carry ripple, C_EN and adder_rst pulse counts
        start_op(8'hFF, 8'h01);
        wait_done("ripple");
        chk("ripple_cen_cnt", cen_cnt, 32'd8);
        chk("ripple_arst_cnt", arst_cnt, 32'd1);
        chk("ripple_arst_cyc", arst_cyc, t0 + 1);
        @(negedge clk);

        // Zero operands, then carry must have been cleared
        start_op(8'h00, 8'h00);
        wait_done("zero");
        @(negedge clk);
        start_op(8'h0F, 8'h01);
        wait_done("carry_clear");
        @(negedge clk);

        // Start while busy during bit 3
        start_op(8'h12, 8'h34);
        repeat (7) @(negedge clk);
        num1 = 8'h11;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("busy_start");
        repeat (25) @(negedge clk);
        chk("busy_start_done_cnt", done_cnt, 32'd1);

        // Asynchronous reset during bit 4
        start_op(8'h55, 8'h0A);
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_cen", {31'b0, C_EN}, 32'd0);
        chk("abort_result", {24'b0, result}, 32'd0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_op(8'h01, 8'h02);
        wait_done("after_abort");
        @(negedge clk);

        // Back-to-back: start in DONE ignored, start in next IDLE accepted
        start_op(8'h20, 8'h22);
        wait_done("b2b_first");
        num1 = 8'h77;
        num2 = 8'h01;
        start = 1'b1;
        @(negedge clk);
        chk("b2b_idle_busy", {31'b0, busy}, 32'd0);
        start_op(8'h30, 8'h05);
        repeat (8) @(negedge clk);
        chk("b2b_result_held", {24'b0, result}, 32'h42);
        wait_done("b2b_second");
        repeat (25) @(negedge clk);
        chk("b2b_done_cnt", done_cnt, 32'd1);
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
